// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide over WIDTH
// iterations, followed by a sign-fix cycle that writes the architectural HI/LO registers.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic                 is_div_q, is_div_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic                 dz_q, dz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 divzero_q, divzero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sgn_s;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_rem_s, div_diff_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quot_s, remd_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (count_q == LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration of each algorithm plus the signed magnitudes of the incoming operands
    always_comb begin
        sgn_s      = ~op_i[0];
        mag_a_s    = mag(rs_i, sgn_s);
        mag_b_s    = mag(rt_i, sgn_s);
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        div_rem_s  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff_s = div_rem_s - {1'b0, opa_q};
        prod_s     = qsign_q ? -acc_q : acc_q;
        quot_s     = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remd_s     = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Internal datapath next state: operand latch in IDLE, iteration in CALC
    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        is_div_d = is_div_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d  = {CW{1'b0}};
                    is_div_d = op_i[1];
                    qsign_d  = sgn_s & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                    rsign_d  = sgn_s & rs_i[WIDTH-1];
                    dz_d     = op_i[1] & (rt_i == {WIDTH{1'b0}});
                    if (op_i[1]) begin
                        opa_d = mag_b_s;
                        acc_d = {{WIDTH{1'b0}}, mag_a_s};
                    end else begin
                        opa_d = mag_a_s;
                        acc_d = {{WIDTH{1'b0}}, mag_b_s};
                    end
                end else begin
                    count_d = count_q;
                end
            end
            S_CALC: begin
                count_d = count_q + CW'(1);
                if (is_div_q) begin
                    // A zero divisor never borrows, so the remainder ends up as |rs|
                    if (!div_diff_s[WIDTH]) begin
                        acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX:   count_d = {CW{1'b0}};
            default: count_d = {CW{1'b0}};
        endcase
    end

    // Output next state: result write in FIX, direct HI/LO writes in IDLE
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                    if (mthi_i) begin
                        hi_d = wdata_i;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtlo_i) begin
                        lo_d = wdata_i;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_CALC: busy_d = 1'b1;
            S_FIX: begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                divzero_d = is_div_q & dz_q;
                if (is_div_q) begin
                    hi_d = remd_s;
                    lo_d = dz_q ? {WIDTH{1'b1}} : quot_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q   <= {CW{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            opa_q     <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign divzero_o = divzero_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] rs, rt, wdata;
    logic         busy, done, divzero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .op_i      (op),
        .rs_i      (rs),
        .rt_i      (rt),
        .mthi_i    (mthi),
        .mtlo_i    (mtlo),
        .wdata_i   (wdata),
        .busy_o    (busy),
        .done_o    (done),
        .divzero_o (divzero),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // poke_kind 1: extra starts while busy; poke_kind 2: mtlo while busy
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int poke_kind,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int lat;
        int busy_low;
        logic [31:0] hold_hi, hold_lo;
        @(negedge clk);
        hold_hi = hi;
        hold_lo = lo;
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = 2'b00; rs = 32'h0; rt = 32'h0;
        lat = 0;
        busy_low = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_low++;
            if (lat == 16) begin
                check_eq({tag, " hold_hi"}, 64'(hi), 64'(hold_hi));
                check_eq({tag, " hold_lo"}, 64'(lo), 64'(hold_lo));
            end
            start = (poke_kind == 1) && (lat == 5 || lat == 6);
            op    = start ? 2'b11 : 2'b00;
            rs    = start ? 32'd100 : 32'h0;
            rt    = start ? 32'd7 : 32'h0;
            mtlo  = (poke_kind == 2) && (lat == 10);
            wdata = 32'h0000_00AA;
            @(negedge clk);
            lat++;
        end
        start = 1'b0; mtlo = 1'b0; op = 2'b00; rs = 32'h0; rt = 32'h0;
        check_eq({tag, " latency"}, 64'(lat), 64'd33);
        check_eq({tag, " busy_gaps"}, 64'(busy_low), 64'd0);
        check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check_eq({tag, " divzero"}, 64'(divzero), 64'(exp_dz));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; rs = 32'h0; rt = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst done", 64'(done), 64'd0);
        check_eq("rst divzero", 64'(divzero), 64'd0);
        check_eq("rst hi", 64'(hi), 64'd0);
        check_eq("rst lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op("mult_7_m3",   2'b00, 32'd7,         32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_min",    2'b00, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100_7",  2'b11, 32'd100,       32'd7,         0, 32'd2,         32'd14,        1'b0);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_5_0",    2'b11, 32'd5,         32'd0,         0, 32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("div_5_0",     2'b10, 32'd5,         32'd0,         0, 32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("div_m7_0",    2'b10, 32'hFFFF_FFF9, 32'd0,         0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_2_3",   2'b01, 32'd2,         32'd3,         0, 32'd0,         32'd6,         1'b0);

        run_op("multu_start_busy", 2'b01, 32'd3, 32'd4, 1, 32'd0, 32'd12, 1'b0);
        @(negedge clk);
        check_eq("no_restart busy", 64'(busy), 64'd0);
        check_eq("no_restart lo", 64'(lo), 64'd12);

        run_op("multu_mtlo_busy", 2'b01, 32'd2, 32'd5, 2, 32'd0, 32'd10, 1'b0);
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h0000_0055;
        @(negedge clk);
        mthi = 1'b0; wdata = 32'h0;
        check_eq("mthi hi", 64'(hi), 64'h55);
        check_eq("mthi lo", 64'(lo), 64'd10);
        check_eq("mthi done", 64'(done), 64'd0);

        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd1000; rt = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 2'b00; rs = 32'h0; rt = 32'h0;
        repeat (9) @(negedge clk);
        check_eq("pre_reset busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst busy", 64'(busy), 64'd0);
        check_eq("async_rst hi", 64'(hi), 64'd0);
        check_eq("async_rst lo", 64'(lo), 64'd0);
        check_eq("async_rst done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("multu_6_7", 2'b01, 32'd6, 32'd7, 0, 32'd0, 32'd42, 1'b0);
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
